// File: rtl/alarm_sequencer_if.sv
// ============================================================================
// alarm_sequencer_if : switch, time and alarm signals of the alarm sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alarm_sequencer_if;
  logic       sec_tick;
  logic [5:0] cur_hours;
  logic [5:0] cur_mins;
  logic [5:0] cur_secs;
  logic       cur_am_pm;
  logic [5:0] D_hours;
  logic [5:0] D_Mins;
  logic [5:0] D_secs;
  logic       AM_PM;
  logic       LoadTime;
  logic       LoadAlarm;
  logic       AlarmEnable;
  logic       snooze;
  logic       stop;
  logic       time_load_strobe;
  logic       load_error;
  logic [5:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic       alarm_am_pm;
  logic       ringing;
  logic       buzzer;
  logic [1:0] state;

  modport master (
    output sec_tick, cur_hours, cur_mins, cur_secs, cur_am_pm,
    output D_hours, D_Mins, D_secs, AM_PM,
    output LoadTime, LoadAlarm, AlarmEnable, snooze, stop,
    input  time_load_strobe, load_error, alarm_hours, alarm_mins, alarm_am_pm,
    input  ringing, buzzer, state
  );

  modport slave (
    input  sec_tick, cur_hours, cur_mins, cur_secs, cur_am_pm,
    input  D_hours, D_Mins, D_secs, AM_PM,
    input  LoadTime, LoadAlarm, AlarmEnable, snooze, stop,
    output time_load_strobe, load_error, alarm_hours, alarm_mins, alarm_am_pm,
    output ringing, buzzer, state
  );
endinterface

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// ============================================================================
// alarm_sequencer : load arbitration, alarm register and ring/snooze control
// Revision: 1.0
// ============================================================================
`default_nettype none

module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  wire logic         fpgaGlobalClock,
  input  wire logic         n_Reset,
  alarm_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_RINGING  = 2'b01;
  localparam logic [1:0] ST_SNOOZING = 2'b10;

  localparam int IDX_LT = 0;
  localparam int IDX_LA = 1;
  localparam int IDX_EN = 2;
  localparam int IDX_SN = 3;
  localparam int IDX_SP = 4;

  localparam logic [8:0] RING_LOAD   = 9'(RING_SECS);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS);

  logic [4:0] raw_in;
  logic [4:0] meta_q, meta_d;
  logic [4:0] sync_q, sync_d;
  logic [4:0] dly_q,  dly_d;
  logic [4:0] rise;

  logic [1:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       time_load_strobe_q, time_load_strobe_d;
  logic       load_error_q, load_error_d;
  logic [5:0] alarm_hours_q, alarm_hours_d;
  logic [5:0] alarm_mins_q, alarm_mins_d;
  logic       alarm_am_pm_q, alarm_am_pm_d;
  logic       ringing_q, ringing_d;
  logic       buzzer_q, buzzer_d;

  logic hours_ok, mins_ok, secs_ok;
  logic time_valid, alarm_valid;
  logic time_req, alarm_req, alarm_cap;
  logic en_sync, match;

  assign raw_in = {bus.stop, bus.snooze, bus.AlarmEnable, bus.LoadAlarm, bus.LoadTime};

  // two metastability flops, third flop only remembers the previous level
  always_comb begin
    meta_d = raw_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  assign rise    = sync_q & ~dly_q;
  assign en_sync = sync_q[IDX_EN];

  assign hours_ok    = (bus.D_hours >= 6'd1) && (bus.D_hours <= 6'd12);
  assign mins_ok     = (bus.D_Mins <= 6'd59);
  assign secs_ok     = (bus.D_secs <= 6'd59);
  assign time_valid  = hours_ok && mins_ok && secs_ok;
  assign alarm_valid = hours_ok && mins_ok;

  // a LoadAlarm edge coinciding with a LoadTime edge is dropped outright
  assign time_req  = rise[IDX_LT];
  assign alarm_req = rise[IDX_LA] && !rise[IDX_LT];
  assign alarm_cap = alarm_req && alarm_valid;

  assign match = bus.sec_tick && en_sync &&
                 (bus.cur_hours == alarm_hours_q) &&
                 (bus.cur_mins  == alarm_mins_q)  &&
                 (bus.cur_am_pm == alarm_am_pm_q) &&
                 (bus.cur_secs  == 6'd0);

  always_ff @(posedge fpgaGlobalClock or negedge n_Reset) begin
    if (!n_Reset) begin
      meta_q             <= '0;
      sync_q             <= '0;
      dly_q              <= '0;
      state_q            <= ST_IDLE;
      cnt_q              <= '0;
      time_load_strobe_q <= 1'b0;
      load_error_q       <= 1'b0;
      alarm_hours_q      <= 6'd12;
      alarm_mins_q       <= 6'd0;
      alarm_am_pm_q      <= 1'b0;
      ringing_q          <= 1'b0;
      buzzer_q           <= 1'b0;
    end else begin
      meta_q             <= meta_d;
      sync_q             <= sync_d;
      dly_q              <= dly_d;
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      time_load_strobe_q <= time_load_strobe_d;
      load_error_q       <= load_error_d;
      alarm_hours_q      <= alarm_hours_d;
      alarm_mins_q       <= alarm_mins_d;
      alarm_am_pm_q      <= alarm_am_pm_d;
      ringing_q          <= ringing_d;
      buzzer_q           <= buzzer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_sync || alarm_cap) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d = ST_RINGING;
            cnt_d   = RING_LOAD;
          end
        end
        ST_RINGING: begin
          if (rise[IDX_SP]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (rise[IDX_SN]) begin
            state_d = ST_SNOOZING;
            cnt_d   = SNOOZE_LOAD;
          end else if (bus.sec_tick) begin
            if (cnt_q <= 9'd1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 9'd1;
            end
          end
        end
        ST_SNOOZING: begin
          if (rise[IDX_SP]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (bus.sec_tick) begin
            if (cnt_q <= 9'd1) begin
              state_d = ST_RINGING;
              cnt_d   = RING_LOAD;
            end else begin
              cnt_d = cnt_q - 9'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    time_load_strobe_d = time_req && time_valid;
    load_error_d       = (time_req && !time_valid) || (alarm_req && !alarm_valid);
    alarm_hours_d      = alarm_cap ? bus.D_hours : alarm_hours_q;
    alarm_mins_d       = alarm_cap ? bus.D_Mins  : alarm_mins_q;
    alarm_am_pm_d      = alarm_cap ? bus.AM_PM   : alarm_am_pm_q;
    ringing_d          = (state_d == ST_RINGING);
    // buzzer restarts high on every entry to RINGING, then toggles per second
    if (state_d != ST_RINGING) begin
      buzzer_d = 1'b0;
    end else if (state_q != ST_RINGING) begin
      buzzer_d = 1'b1;
    end else if (bus.sec_tick) begin
      buzzer_d = !buzzer_q;
    end else begin
      buzzer_d = buzzer_q;
    end
  end

  assign bus.time_load_strobe = time_load_strobe_q;
  assign bus.load_error       = load_error_q;
  assign bus.alarm_hours      = alarm_hours_q;
  assign bus.alarm_mins       = alarm_mins_q;
  assign bus.alarm_am_pm      = alarm_am_pm_q;
  assign bus.ringing          = ringing_q;
  assign bus.buzzer           = buzzer_q;
  assign bus.state            = state_q;

endmodule

`default_nettype wire

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Sequences load and alarm control for the digital alarm clock, alongside the time-keeping datapath.
- Arbitrates the LoadTime / LoadAlarm switch requests. Validates the switch-entered hours/mins/secs and holds the alarm register.
- Compares running time against the alarm and runs the ring/snooze state machine that drives the buzzer.
- Sits between the board switches and the `main` time counter; the counter consumes `time_load_strobe`.

Parameters:
RING_SECS, 60, seconds of ringing before auto-stop (1..511)
SNOOZE_SECS, 300, seconds of snooze before re-ring (1..511)

Ports:
fpgaGlobalClock  in  1  system clock, all flops rising-edge
n_Reset  in  1  asynchronous active-low reset
sec_tick  in  1  one-cycle 1 Hz enable, aligned to fpgaGlobalClock
cur_hours / cur_mins / cur_secs  in  6 each  running time, binary (hours 1..12)
cur_am_pm  in  1  running AM(0)/PM(1)
D_hours / D_Mins / D_secs  in  6 each  switch-entered value, binary
AM_PM  in  1  switch-entered AM/PM
LoadTime / LoadAlarm  in  1 each  level switches, asynchronous to clock
AlarmEnable  in  1  level switch, asynchronous
snooze / stop  in  1 each  push buttons, asynchronous, active-high
time_load_strobe  out  1  one-cycle pulse: time counter loads D_* values
load_error  out  1  one-cycle pulse: entered value rejected
alarm_hours / alarm_mins  out  6 each  stored alarm
alarm_am_pm  out  1  stored alarm AM/PM
ringing  out  1  high in RINGING
buzzer  out  1  ring drive
state  out  2  00 IDLE, 01 RINGING, 10 SNOOZING

Behaviour:
- Reset (async assert, sync release): state IDLE; alarm register 12:00 AM (hours=12, mins=0, am_pm=0).
  - time_load_strobe, load_error, ringing and buzzer are 0; ring/snooze counter is 0.
- Input sync: LoadTime, LoadAlarm, AlarmEnable, snooze and stop each pass through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - Edge-driven outputs register one cycle later.
  - Latency: pin rises before clock edge E1 -> registered response visible after E3, i.e. 3 clocks.
- Validation: entry is valid iff D_hours in 1..12, D_Mins <= 59 and D_secs <= 59. D_secs is checked for LoadTime only.
  - Invalid -> load_error pulses 1 cycle; nothing else changes.
- Load arbitration (same cycle):
  - LoadTime edge only, valid: time_load_strobe pulses 1 cycle. State is unaffected.
  - LoadAlarm edge only, valid: the alarm register captures D_hours, D_Mins and AM_PM. State forced to IDLE, counter cleared.
  - Both edges in the same cycle: LoadTime wins and the LoadAlarm edge is discarded (not deferred).
  - D_* are sampled in the cycle the strobe/capture is registered. Inputs must be stable 3 cycles before and during the switch edge.
- Match: asserts in a cycle when all of the following hold:
  - sec_tick=1 and AlarmEnable(sync)=1;
  - cur_hours==alarm_hours, cur_mins==alarm_mins, cur_am_pm==alarm_am_pm;
  - cur_secs==0.
- FSM, evaluated every clock. Priority order is 1 (highest) to 3 within each state:
  - Any state: AlarmEnable(sync)=0 -> IDLE immediately, counter cleared.
  - IDLE:
    1. match -> RINGING, counter=RING_SECS.
  - RINGING:
    1. stop edge -> IDLE.
    2. snooze edge -> SNOOZING, counter=SNOOZE_SECS.
    3. sec_tick: counter decrements. If counter was 1 -> IDLE.
    - Stop/snooze edge coinciding with sec_tick: the edge wins and the tick is ignored.
  - SNOOZING:
    1. stop edge -> IDLE.
    2. sec_tick: decrement. If counter was 1 -> RINGING, counter=RING_SECS.
    - snooze edge is ignored.
    - Match during SNOOZING is ignored.
- Counter: 9 bits, decrements only on sec_tick, never wraps below 0.
- ringing = (state==RINGING), registered.
- buzzer: set to 1 on entry to RINGING. Toggles on each sec_tick while RINGING; 0 in all other states.
- Mid-operation reset: all of the above reset values apply immediately; a pending pulse is dropped.

Test Plan:
1. Reset, then LoadAlarm rise with D_hours=7, D_Mins=30, AM_PM=0 -> after 3 clocks alarm=7:30 AM, load_error=0, state=IDLE.
2. LoadTime rise with D_hours=13 -> load_error high for exactly 1 cycle, time_load_strobe stays 0. Repeat with D_hours=12, D_Mins=59, D_secs=59 -> single time_load_strobe.
3. LoadTime and LoadAlarm rise in the same cycle with valid data -> one time_load_strobe; alarm register unchanged.
4. AlarmEnable=1, alarm 7:30 AM, cur=7:30:00 AM with sec_tick -> state=01 next cycle, ringing=1, buzzer=1. RING_SECS=4 -> buzzer toggles 3 times, back to IDLE on the 4th tick.
5. While RINGING, snooze edge coincident with sec_tick -> SNOOZING, counter=SNOOZE_SECS. With SNOOZE_SECS=3, three ticks later -> RINGING with counter=RING_SECS. Then stop edge -> IDLE.
6. While SNOOZING, drop AlarmEnable -> IDLE and buzzer=0 within 3 clocks. Assert n_Reset=0 while RINGING -> ringing/buzzer 0 immediately and alarm returns to 12:00 AM.
